// File: rtl/inv_pkg.sv
// Shared types for the vector inverter pipeline: lane operation modes and skid-buffer states.
package inv_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        NOT  = 2'b01,
        NEG  = 2'b10,
        ABS  = 2'b11
    } inv_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/inv_lane.sv
// Combinational single-lane operator: pass, invert, negate or absolute value with
// overflow on the most-negative operand.
module inv_lane
    import inv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  inv_mode_t        i_mode,
    output logic [WIDTH-1:0] o_y,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_neg;
    logic             w_is_min;

    // Negating the most-negative value wraps back to itself, which is the required result.
    assign w_neg    = ~i_x + WIDTH'(1);
    assign w_is_min = (i_x == MinVal);

    always_comb begin
        o_y   = i_x;
        o_ovf = 1'b0;
        unique case (i_mode)
            PASS: o_y = i_x;
            NOT:  o_y = ~i_x;
            NEG: begin
                o_y   = w_neg;
                o_ovf = w_is_min;
            end
            ABS: begin
                o_y   = i_x[WIDTH-1] ? w_neg : i_x;
                o_ovf = w_is_min;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inv_vec_pipe.sv
// Multi-lane inverter with a registered ready/valid output stage and 2-entry skid buffer.
// Optional transfer/overflow statistics counters are enabled by defining INV_STATS_EN.
module inv_vec_pipe
    import inv_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [MODE_W-1:0]      i_in_mode,
    input  logic [LANES*WIDTH-1:0] i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*WIDTH-1:0] o_out_data,
    output logic [LANES-1:0]       o_out_ovf,
    output logic [MODE_W-1:0]      o_out_mode
`ifdef INV_STATS_EN
    ,
    output logic [31:0]            o_stat_xfer,
    output logic [31:0]            o_stat_ovf
`endif
);

    localparam int unsigned DW = LANES * WIDTH;

    inv_mode_t      w_mode;
    logic [DW-1:0]  w_res;
    logic [LANES-1:0] w_ovf;

    assign w_mode = inv_mode_t'(i_in_mode);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .i_x    (i_in_data[g*WIDTH +: WIDTH]),
            .i_mode (w_mode),
            .o_y    (w_res[g*WIDTH +: WIDTH]),
            .o_ovf  (w_ovf[g])
        );
    end

    skid_state_t      r_state, w_state_next;
    logic             w_in_xfer, w_out_xfer;
    logic             w_load_m_in, w_load_m_skid, w_load_s;

    logic [DW-1:0]     r_m_data, r_s_data;
    logic [LANES-1:0]  r_m_ovf, r_s_ovf;
    logic [MODE_W-1:0] r_m_mode, r_s_mode;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign o_in_ready  = (r_state != FULL);
    assign o_out_valid = (r_state != EMPTY);
    assign w_in_xfer   = i_in_valid && o_in_ready;
    assign w_out_xfer  = o_out_valid && i_out_ready;

    always_comb begin
        w_state_next  = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_next = ONE;
                    w_load_m_in  = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_m_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_next = FULL;
                    w_load_s     = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_state_next  = ONE;
                    w_load_m_skid = 1'b1;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_m_data <= '0;
            r_m_ovf  <= '0;
            r_m_mode <= '0;
            r_s_data <= '0;
            r_s_ovf  <= '0;
            r_s_mode <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_data <= w_res;
                r_m_ovf  <= w_ovf;
                r_m_mode <= i_in_mode;
            end else if (w_load_m_skid) begin
                r_m_data <= r_s_data;
                r_m_ovf  <= r_s_ovf;
                r_m_mode <= r_s_mode;
            end
            if (w_load_s) begin
                r_s_data <= w_res;
                r_s_ovf  <= w_ovf;
                r_s_mode <= i_in_mode;
            end
        end
    end

    assign o_out_data = r_m_data;
    assign o_out_ovf  = r_m_ovf;
    assign o_out_mode = r_m_mode;

`ifdef INV_STATS_EN
    logic [31:0] r_stat_xfer, r_stat_ovf;
    logic [31:0] w_pop;
    logic [32:0] w_ovf_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + {31'b0, r_m_ovf[i]};
        end
        w_ovf_sum = {1'b0, r_stat_ovf} + {1'b0, w_pop};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_xfer <= '0;
            r_stat_ovf  <= '0;
        end else if (w_out_xfer) begin
            if (r_stat_xfer != '1) begin
                r_stat_xfer <= r_stat_xfer + 32'd1;
            end
            r_stat_ovf <= w_ovf_sum[32] ? '1 : w_ovf_sum[31:0];
        end
    end

    assign o_stat_xfer = r_stat_xfer;
    assign o_stat_ovf  = r_stat_ovf;
`endif

endmodule

// File: tb/tb_inv_vec_pipe.sv
// Self-checking bench for inv_vec_pipe: directed mode vectors, skid backpressure, random
// throughput against an arithmetic reference model, mid-run reset, optional INV_STATS_EN counters.
module tb_inv_vec_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned DW = W * L;

    typedef struct packed {
        logic [1:0]    mode;
        logic [L-1:0]  ovf;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'b00;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [L-1:0]  out_ovf;
    logic [1:0]    out_mode;
`ifdef INV_STATS_EN
    logic [31:0]   stat_xfer, stat_ovf;
`endif

    int   checks = 0;
    int   failures = 0;
    bit   last_in;
    txn_t obs_q[$];
    txn_t exp_q[$];

    inv_vec_pipe #(
        .WIDTH (W),
        .LANES (L)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_mode   (in_mode),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_ovf   (out_ovf),
        .o_out_mode  (out_mode)
`ifdef INV_STATS_EN
        ,
        .o_stat_xfer (stat_xfer),
        .o_stat_ovf  (stat_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: each lane treated as an unsigned integer modulo 2^W.
    function automatic txn_t model(logic [1:0] mode, logic [DW-1:0] d);
        txn_t        t;
        int unsigned m, x, y;
        m = 1 << W;
        t.mode = mode;
        t.ovf  = '0;
        t.data = '0;
        for (int i = 0; i < L; i++) begin
            x = 32'(d[i*W +: W]);
            case (mode)
                2'd0:    y = x;
                2'd1:    y = m - 1 - x;
                2'd2:    y = (m - x) % m;
                default: y = (x >= m / 2) ? (m - x) % m : x;
            endcase
            t.data[i*W +: W] = y[W-1:0];
            t.ovf[i] = (mode >= 2) && (x == m / 2);
        end
        return t;
    endfunction

    // Records handshakes that will happen at the coming edge, then advances one cycle.
    task automatic cycle();
        txn_t t;
        last_in = 1'b0;
        if (!reset) begin
            if (out_valid && out_ready) begin
                t.mode = out_mode;
                t.ovf  = out_ovf;
                t.data = out_data;
                obs_q.push_back(t);
            end
            last_in = in_valid && in_ready;
            if (last_in) exp_q.push_back(model(in_mode, in_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_txn();
        in_mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < L; i++) begin
            in_data[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'(1 << (W - 1)) : W'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", out_data); end
        if (out_ovf !== '0) begin failures++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        if (out_mode !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b want 00", out_mode); end
        reset = 1'b0;
        cycle();
    endtask

`ifdef INV_STATS_EN
    task automatic test_stats();
        checks++;
        if (stat_xfer !== 32'd0) begin failures++; $display("FAIL stats_reset: got %0d want 0", stat_xfer); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 2'b10; in_data = 32'h01010180; cycle();
        in_mode = 2'b11; in_data = 32'h05050580; cycle();
        in_mode = 2'b00; in_data = 32'h80808080; cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        checks += 2;
        if (stat_xfer !== 32'd3) begin failures++; $display("FAIL stats_xfer: got %0d want 3", stat_xfer); end
        if (stat_ovf !== 32'd2) begin failures++; $display("FAIL stats_ovf: got %0d want 2", stat_ovf); end
    endtask
`endif

    task automatic test_not();
        obs_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_data  = 32'hFFAA0F00;
        cycle();
        in_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL not_valid: got %b want 1", out_valid); end
        if (out_data !== 32'h0055F0FF) begin failures++; $display("FAIL not_data: got %h want 0055f0ff", out_data); end
        if (out_ovf !== 4'b0000) begin failures++; $display("FAIL not_ovf: got %b want 0000", out_ovf); end
        if (out_mode !== 2'b01) begin failures++; $display("FAIL not_mode: got %b want 01", out_mode); end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL not_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_neg_abs();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode  = 2'b10;
        in_data  = 32'h7F000180;
        cycle();
        in_mode  = 2'b11;
        in_data  = 32'h8105FE80;
        checks += 2;
        if (out_data !== 32'h8100FF80) begin failures++; $display("FAIL neg_data: got %h want 8100ff80", out_data); end
        if (out_ovf !== 4'b0001) begin failures++; $display("FAIL neg_ovf: got %b want 0001", out_ovf); end
        cycle();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL abs_valid: got %b want 1", out_valid); end
        if (out_data !== 32'h7F050280) begin failures++; $display("FAIL abs_data: got %h want 7f050280", out_data); end
        if (out_ovf !== 4'b0001) begin failures++; $display("FAIL abs_ovf: got %b want 0001", out_ovf); end
        cycle();
    endtask

    task automatic test_backpressure();
        txn_t exp_l[3];
        txn_t held;
        int   n_in;
        obs_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n_in = 0;
        rand_txn(); exp_l[0] = model(in_mode, in_data);
        cycle();
        rand_txn(); exp_l[1] = model(in_mode, in_data);
        cycle();
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        if (out_data !== exp_l[0].data) begin failures++; $display("FAIL bp_head: got %h want %h", out_data, exp_l[0].data); end
        rand_txn(); exp_l[2] = model(in_mode, in_data);
        held.mode = out_mode; held.ovf = out_ovf; held.data = out_data;
        for (int i = 0; i < 3; i++) cycle();
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
        if ({out_mode, out_ovf, out_data} !== held) begin
            failures++; $display("FAIL bp_stable: got %h want %h", {out_mode, out_ovf, out_data}, held);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_in) in_valid = 1'b0;
        end
        checks++;
        if (obs_q.size() != 3) begin
            failures++; $display("FAIL bp_count: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_l[i]) begin
                    failures++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_q[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_throughput();
        int cyc;
        int n_in;
        obs_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rand_txn();
        cyc = 0;
        n_in = 0;
        while (obs_q.size() < 100 && cyc < 300) begin
            cycle();
            cyc++;
            if (last_in) begin
                n_in++;
                if (n_in == 100) in_valid = 1'b0;
                else rand_txn();
            end
        end
        checks += 2;
        if (cyc != 101) begin failures++; $display("FAIL tp_cycles: got %0d want 101", cyc); end
        if (obs_q.size() != 100 || exp_q.size() != 100) begin
            failures++; $display("FAIL tp_count: got %0d/%0d want 100", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL tp_item[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_txn(); cycle();
        rand_txn(); cycle();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_full: got %b want 0", in_ready); end
        rand_txn();
        out_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready: got %b want 1", in_ready); end
        if (out_data !== '0) begin failures++; $display("FAIL rm_data: got %h want 0", out_data); end
        if (out_ovf !== '0) begin failures++; $display("FAIL rm_ovf: got %b want 0", out_ovf); end
        if (out_mode !== 2'b00) begin failures++; $display("FAIL rm_mode: got %b want 00", out_mode); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_stale[%0d]: got %b want 0", i, out_valid); end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rm_obs: got %0d want 0", obs_q.size()); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
`ifdef INV_STATS_EN
        test_stats();
`endif
        test_not();
        test_neg_abs();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
